// File: rtl/pipe_hazard_ctrl.sv
// Scoreboard pipeline sequencer: per-register busy countdowns drive IF/ID stall,
// EXE bubble and ID flush, with memory freeze and drain-to-halt sequencing.
module pipe_hazard_ctrl #(
    parameter int WIDTH   = 32,
    parameter int NREGS   = 32,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] IR_ID,
    input  logic             ID_Valid,
    input  logic             BranchTaken_EXE,
    input  logic             MemBusy,
    output logic             IsStall_IF,
    output logic             IsStall_ID,
    output logic             Bubble_EXE,
    output logic             Flush_ID,
    output logic             Halted,
    output logic [CNT_W-1:0] StallCount
);
    localparam int RW = 5;
    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_HALT = 6'h3F;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [2:0]        drain_r, drain_nxt_s;
    logic [1:0]        busy_cnt_r [NREGS];
    logic [CNT_W-1:0]  stall_cnt_r;
    logic              halted_r;

    logic [5:0]        op_s;
    logic [RW-1:0]     rd_s, rs_s, rt_s;
    logic              checked_s, is_halt_s, hazard_s;
    logic              stall_s, bubble_s, flush_s, dec_s, load_s, cnt_inc_s;
    logic              unused_ir_s;

    function automatic logic reg_busy(input logic [RW-1:0] idx, input logic [1:0] cnt);
        return (idx != {RW{1'b0}}) && (cnt != 2'd0);
    endfunction

    assign op_s        = IR_ID[31:26];
    assign rd_s        = IR_ID[25:21];
    assign rs_s        = IR_ID[20:16];
    assign rt_s        = IR_ID[15:11];
    assign unused_ir_s = ^IR_ID[10:0];

    // ID_Valid=0 makes the slot a NOP, so it is neither checked nor a writer.
    assign checked_s = ID_Valid && (op_s != OP_J) && (op_s != OP_JAL)
                       && (op_s != OP_NOP) && (op_s != OP_HALT);
    assign is_halt_s = ID_Valid && (op_s == OP_HALT);
    assign hazard_s  = checked_s && (reg_busy(rs_s, busy_cnt_r[rs_s])
                                     || reg_busy(rt_s, busy_cnt_r[rt_s]));

    // Next-state and per-cycle control decode, priority ordered within RUN.
    always_comb begin
        state_nxt_s = state_r;
        drain_nxt_s = drain_r;
        stall_s     = 1'b0;
        bubble_s    = 1'b0;
        flush_s     = 1'b0;
        dec_s       = 1'b0;
        load_s      = 1'b0;
        cnt_inc_s   = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (MemBusy) begin
                    stall_s = 1'b1;
                end else if (BranchTaken_EXE) begin
                    flush_s  = 1'b1;
                    bubble_s = 1'b1;
                    dec_s    = 1'b1;
                end else if (hazard_s) begin
                    stall_s   = 1'b1;
                    bubble_s  = 1'b1;
                    dec_s     = 1'b1;
                    cnt_inc_s = 1'b1;
                end else begin
                    dec_s  = 1'b1;
                    load_s = checked_s && (rd_s != {RW{1'b0}});
                    if (is_halt_s) begin
                        state_nxt_s = ST_DRAIN;
                        drain_nxt_s = 3'(LATENCY + 1);
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
            end
            ST_DRAIN: begin
                stall_s  = 1'b1;
                bubble_s = 1'b1;
                if (!MemBusy) begin
                    dec_s       = 1'b1;
                    drain_nxt_s = drain_r - 3'd1;
                    if (drain_r == 3'd1) begin
                        state_nxt_s = ST_HALTED;
                    end else begin
                        state_nxt_s = ST_DRAIN;
                    end
                end else begin
                    drain_nxt_s = drain_r;
                end
            end
            ST_HALTED: begin
                stall_s  = 1'b1;
                bubble_s = 1'b1;
                dec_s    = 1'b1;
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // FSM, drain timer, halt flag and saturating hazard-stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_RUN;
            drain_r     <= 3'd0;
            halted_r    <= 1'b0;
            stall_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            drain_r  <= drain_nxt_s;
            halted_r <= (state_nxt_s == ST_HALTED);
            if (cnt_inc_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    // Busy countdowns; a fresh issue to Rd overrides that register's decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                busy_cnt_r[i] <= 2'd0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (i == 0) begin
                    busy_cnt_r[i] <= 2'd0;
                end else if (load_s && (rd_s == RW'(i))) begin
                    busy_cnt_r[i] <= 2'(LATENCY);
                end else if (dec_s && (busy_cnt_r[i] != 2'd0)) begin
                    busy_cnt_r[i] <= busy_cnt_r[i] - 2'd1;
                end else begin
                    busy_cnt_r[i] <= busy_cnt_r[i];
                end
            end
        end
    end

    assign IsStall_IF = rst_n & stall_s;
    assign IsStall_ID = rst_n & stall_s;
    assign Bubble_EXE = rst_n & bubble_s;
    assign Flush_ID   = rst_n & flush_s;
    assign Halted     = halted_r;
    assign StallCount = stall_cnt_r;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Scoreboard-based pipeline sequencer for the 5-stage core. It sits between the ID stage and the IF/ID/EXE pipeline registers.
- Tracks in-flight register writes per register. Generates IF/ID stall, EXE bubble and ID flush.
- Freezes the pipe during memory wait. Sequences drain-to-halt on HALT.
- Replaces per-cycle IR comparison with a registered per-register countdown, and adds branch-flush, memory-freeze and halt sequencing.

Parameters:
- WIDTH, 32, instruction width
- NREGS, 32, architectural registers; index width 5
- LATENCY, 2, cycles a destination stays busy after issue (legal 1..3)
- CNT_W, 16, width of stall statistics counter

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- IR_ID  in  WIDTH  instruction in ID; Op=[31:26], Rd=[25:21], Rs=[20:16], Rt=[15:11]
- ID_Valid  in  1  IR_ID holds a real instruction
- BranchTaken_EXE  in  1  branch/jump resolved taken in EXE this cycle
- MemBusy  in  1  data memory not ready; whole pipe must hold
- IsStall_IF  out  1  hold PC and IF/ID register
- IsStall_ID  out  1  hold ID/EXE inputs
- Bubble_EXE  out  1  load NOP into ID/EXE register
- Flush_ID  out  1  replace IF/ID contents with NOP
- Halted  out  1  core fully drained after HALT
- StallCount  out  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Clock and reset: one clock domain, clk. rst_n is asynchronous and active-low.
- Reset values:
  - all busy counters 0, state RUN, Halted 0, StallCount 0.
  - combinational outputs read 0 while rst_n=0.
  - reset mid-operation aborts any stall, drain or halt immediately.
- Scoreboard:
  - one 2-bit counter per register 1..NREGS-1.
  - R0 is never tracked and always reads not-busy.
- Classification:
  - checked = Op not in {J, JAL, NOP, HALT}.
  - writer = checked.
  - an instruction with ID_Valid=0 is treated as NOP.
- Hazard (combinational, from registered counters):
  - hazard = checked(IR_ID) AND (busy[Rs] OR busy[Rt]).
- Priority each cycle, highest first:
  1. MemBusy=1: IsStall_IF=IsStall_ID=1, Bubble_EXE=0, Flush_ID=0. Counters hold, state holds, StallCount holds.
  2. BranchTaken_EXE=1: Flush_ID=1, Bubble_EXE=1. The ID instruction is not issued and its Rd is not marked. Counters decrement. An IR_ID HALT is ignored.
  3. hazard: IsStall_IF=IsStall_ID=1, Bubble_EXE=1. Counters decrement. StallCount += 1, saturating at all-ones.
  4. otherwise issue: outputs 0. If writer and Rd != 0, counter[Rd] <= LATENCY. All other nonzero counters decrement.
- Same-cycle issue to a register whose counter is decrementing: the load of LATENCY wins.
- Dependent timing with LATENCY=2:
  - producer issues at cycle t.
  - a dependent in ID stalls at t+1 and t+2, and issues at t+3.
- State machine:
  - RUN: normal operation per the priority list.
  - RUN -> DRAIN: HALT in ID with ID_Valid=1 issues (priority 4 reached). It issues as a NOP-class instruction.
  - DRAIN: IsStall_IF=IsStall_ID=1 and Bubble_EXE=1 every cycle. An internal drain counter loads LATENCY+1 and decrements on non-MemBusy cycles. Branch flush is ignored in DRAIN.
  - DRAIN -> HALTED: drain counter reaches 0.
  - HALTED: Halted=1 (registered), all stalls held at 1, Bubble_EXE=1. Leaves only on reset.
- StallCount counts only priority-3 cycles in RUN. It excludes MemBusy, flush and DRAIN cycles.

Test Plan:
- ADD R3<-R1,R2 issues at cycle 10, then SUB R5<-R3,R4 enters ID at 11 -> IsStall_ID=1 at 11 and 12, issue at 13, StallCount=2.
- Producer writes R0, dependent reads R0 -> no stall, StallCount=0.
- Dependent stalled at cycle 11 with MemBusy=1 for cycles 11-13 -> counters frozen; stall continues through cycle 15, issue at 16, StallCount=2.
- BranchTaken_EXE=1 while a hazard is pending in ID -> Flush_ID=1, Bubble_EXE=1, StallCount unchanged, Rd of the flushed instruction not marked.
- Back-to-back writers to R7 at cycles 5 and 6 -> counter[R7]=2 after cycle 6; a reader at cycle 7 stalls at 7 and 8, issues at 9.
- HALT issues at cycle 20, LATENCY=2 -> DRAIN cycles 21-23, Halted=1 from cycle 24. rst_n low at cycle 30 -> Halted=0 immediately, state RUN.
